// File: rtl/serial_subtractor_ctrl_if.sv
// Operand/result bundle for the bit-serial subtractor: request side (start, operands)
// and completion side (busy, done, diff, borrow_out).
interface serial_subtractor_ctrl_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;

  modport master (
    output start, a, b, borrow_in,
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor_ctrl.sv
// Bit-serial unsigned subtractor: one full-subtractor cell, operands consumed LSB-first,
// borrow carried in a flop, result assembled in a shift register then copied to diff.
module serial_subtractor_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  serial_subtractor_ctrl_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [WIDTH-1:0] diff_q;
  logic             brw;
  logic             borrow_q;
  logic [CNT_W-1:0] cnt;
  logic             load;
  logic             step;
  logic             last;
  logic             cell_d;
  logic             cell_b;

  // Returns {borrow_out, diff} of x - y - bin.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    full_sub = {(~x & (y | bin)) | (y & bin), x ^ y ^ bin};
  endfunction

  assign {cell_b, cell_d} = full_sub(a_sr[0], b_sr[0], brw);
  assign last             = (cnt == CNT_LAST);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end
      end
      RUN: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        if (bus.start) begin
          load      = 1'b1;
          state_nxt = RUN;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_sr     <= '0;
      b_sr     <= '0;
      res_sr   <= '0;
      diff_q   <= '0;
      brw      <= 1'b0;
      borrow_q <= 1'b0;
      cnt      <= '0;
    end else if (load) begin
      a_sr <= bus.a;
      b_sr <= bus.b;
      brw  <= bus.borrow_in;
      cnt  <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= {cell_d, res_sr[WIDTH-1:1]};
      brw    <= cell_b;
      cnt    <= cnt + CNT_W'(1);
      // Output copy happens only on the final bit so diff stays stable through the next RUN.
      if (last) begin
        diff_q   <= {cell_d, res_sr[WIDTH-1:1]};
        borrow_q <= cell_b;
      end
    end
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = borrow_q;

endmodule

// File: tb/tb_serial_subtractor_ctrl.sv
// Scoreboard bench for the bit-serial subtractor at WIDTH=8 (directed + random) and WIDTH=13 (random).
module tb_serial_subtractor_ctrl;

  logic clk;
  logic reset;
  int   errs;
  int   checks;

  logic [64:0] q8[$];
  logic [64:0] q13[$];
  logic [64:0] e8;
  logic [64:0] e13;

  serial_subtractor_ctrl_if #(.WIDTH(8))  sif8();
  serial_subtractor_ctrl_if #(.WIDTH(13)) sif13();

  serial_subtractor_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (sif8)
  );

  serial_subtractor_ctrl #(.WIDTH(13)) dut13 (
    .clk   (clk),
    .reset (reset),
    .bus   (sif13)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [64:0] got, input logic [64:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && sif8.done) begin
      check_eq("w8_pending", 65'(q8.size() != 0), 65'd1);
      if (q8.size() != 0) begin
        e8 = q8.pop_front();
        check_eq("w8_result", 65'({sif8.borrow_out, sif8.diff}), e8);
      end
    end
    if (!reset && sif13.done) begin
      check_eq("w13_pending", 65'(q13.size() != 0), 65'd1);
      if (q13.size() != 0) begin
        e13 = q13.pop_front();
        check_eq("w13_result", 65'({sif13.borrow_out, sif13.diff}), e13);
      end
    end
  end

  function automatic logic [64:0] ref8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    logic [8:0] r;
    r = {1'b0, a} - {1'b0, b} - {8'd0, bin};
    return 65'(r);
  endfunction

  function automatic logic [64:0] ref13(input logic [12:0] a, input logic [12:0] b, input logic bin);
    logic [13:0] r;
    r = {1'b0, a} - {1'b0, b} - {13'd0, bin};
    return 65'(r);
  endfunction

  // Issue one WIDTH=8 operation, scramble operands after capture, return at the done sample.
  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    int lat;
    int nb;
    @(negedge clk);
    sif8.start = 1'b1; sif8.a = a; sif8.b = b; sif8.borrow_in = bin;
    q8.push_back(ref8(a, b, bin));
    @(negedge clk);
    sif8.start = 1'b0;
    sif8.a = 8'($urandom); sif8.b = 8'($urandom); sif8.borrow_in = 1'($urandom);
    lat = 1;
    nb  = sif8.busy ? 1 : 0;
    while (!sif8.done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (sif8.busy) nb++;
    end
    check_eq("w8_latency", 65'(lat), 65'd9);
    check_eq("w8_busy_cycles", 65'(nb), 65'd8);
  endtask

  task automatic op13(input logic [12:0] a, input logic [12:0] b, input logic bin);
    int lat;
    @(negedge clk);
    sif13.start = 1'b1; sif13.a = a; sif13.b = b; sif13.borrow_in = bin;
    q13.push_back(ref13(a, b, bin));
    @(negedge clk);
    sif13.start = 1'b0;
    sif13.a = 13'($urandom); sif13.b = 13'($urandom); sif13.borrow_in = 1'($urandom);
    lat = 1;
    while (!sif13.done && lat < 60) begin
      @(negedge clk);
      lat++;
    end
    check_eq("w13_latency", 65'(lat), 65'd14);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int ndone;
    errs   = 0;
    checks = 0;
    reset  = 1'b1;
    sif8.start  = 1'b1; sif8.a  = 8'h12; sif8.b  = 8'h34; sif8.borrow_in  = 1'b0;
    sif13.start = 1'b0; sif13.a = '0;    sif13.b = '0;    sif13.borrow_in = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", 65'(sif8.busy), 65'd0);
    check_eq("rst_done", 65'(sif8.done), 65'd0);
    check_eq("rst_diff", 65'(sif8.diff), 65'd0);
    check_eq("rst_borrow", 65'(sif8.borrow_out), 65'd0);
    check_eq("rst13_out", 65'({sif13.busy, sif13.done, sif13.borrow_out, sif13.diff}), 65'd0);
    sif8.start = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    check_eq("idle_after_rst", 65'(sif8.busy), 65'd0);

    // Basic subtraction, then underflow with incoming borrow.
    op8(8'h5A, 8'h3C, 1'b0);
    @(negedge clk);
    check_eq("done_one_cycle", 65'(sif8.done), 65'd0);
    check_eq("diff_held_idle", 65'(sif8.diff), 65'h1E);
    op8(8'h00, 8'h01, 1'b1);

    // Back-to-back: restart from the DONE cycle; previous result must persist.
    op8(8'hFF, 8'hFF, 1'b0);
    sif8.start = 1'b1; sif8.a = 8'h10; sif8.b = 8'h01; sif8.borrow_in = 1'b0;
    q8.push_back(ref8(8'h10, 8'h01, 1'b0));
    @(negedge clk);
    sif8.start = 1'b0;
    check_eq("b2b_busy", 65'(sif8.busy), 65'd1);
    check_eq("b2b_diff_held", 65'({sif8.borrow_out, sif8.diff}), 65'h000);
    lat = 1;
    while (!sif8.done && lat < 40) begin
      @(negedge clk);
      lat++;
      if (lat == 5) check_eq("b2b_diff_mid", 65'(sif8.diff), 65'h00);
    end
    check_eq("b2b_latency", 65'(lat), 65'd9);

    // start during RUN is ignored.
    @(negedge clk);
    sif8.start = 1'b1; sif8.a = 8'h80; sif8.b = 8'h01; sif8.borrow_in = 1'b0;
    q8.push_back(ref8(8'h80, 8'h01, 1'b0));
    @(negedge clk);
    sif8.start = 1'b0;
    repeat (3) @(negedge clk);
    sif8.start = 1'b1; sif8.a = 8'hFF; sif8.b = 8'h00; sif8.borrow_in = 1'b1;
    @(negedge clk);
    sif8.start = 1'b0;
    lat = 5;
    while (!sif8.done && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check_eq("ignore_latency", 65'(lat), 65'd9);
    @(negedge clk);
    check_eq("ignore_diff", 65'(sif8.diff), 65'h7F);

    // Reset mid-RUN aborts the operation with no done afterwards.
    sif8.start = 1'b1; sif8.a = 8'h33; sif8.b = 8'h11; sif8.borrow_in = 1'b0;
    @(negedge clk);
    sif8.start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_eq("abort_outs", 65'({sif8.busy, sif8.done, sif8.borrow_out, sif8.diff}), 65'd0);
    q8.delete();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    ndone = 0;
    repeat (15) begin
      @(negedge clk);
      if (sif8.done || sif8.busy) ndone++;
    end
    check_eq("abort_no_done", 65'(ndone), 65'd0);

    // Random sweep on both widths in parallel.
    fork
      begin
        for (int i = 0; i < 3000; i++) begin
          op8(8'($urandom), 8'($urandom), 1'($urandom));
        end
      end
      begin
        for (int j = 0; j < 3000; j++) begin
          op13(13'($urandom), 13'($urandom), 1'($urandom));
        end
      end
    join
    repeat (3) @(negedge clk);
    check_eq("w8_q_drained", 65'(q8.size()), 65'd0);
    check_eq("w13_q_drained", 65'(q13.size()), 65'd0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
